// File: rtl/vball_timing_rx_if.sv
// Video timing bundle: sync/blank inputs in, measured geometry and pixel position out.
// The master side (source/observer) drives the syncs; the slave side is the receiver.
interface vball_timing_rx_if;
  logic       hs;
  logic       vs;
  logic       hb;
  logic       vb;
  logic [8:0] x;
  logic [8:0] y;
  logic       de;
  logic [8:0] line_len;
  logic [8:0] frame_lines;
  logic [8:0] active_w;
  logic [8:0] active_h;
  logic       locked;
  logic       err;

  modport master (
    output hs, vs, hb, vb,
    input  x, y, de, line_len, frame_lines, active_w, active_h, locked, err
  );

  modport slave (
    input  hs, vs, hb, vb,
    output x, y, de, line_len, frame_lines, active_w, active_h, locked, err
  );
endinterface

// File: rtl/vball_timing_rx.sv
// Video timing receiver: measures line/frame geometry from sync and blank strobes,
// tracks pixel position and declares lock once the geometry repeats frame to frame.
module vball_timing_rx #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic              clk,
  input logic              reset,
  vball_timing_rx_if.slave vid
);

  localparam logic [8:0] CntMax  = 9'd511;
  localparam logic [1:0] LockCnt = 2'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == CntMax) ? CntMax : v + 9'd1;
  endfunction

  // Delayed copies of the strobes, used only for edge detection.
  logic hs_q, vs_q, hb_q, vb_q;

  logic [8:0] hper_q, hper_d;
  logic [8:0] line_len_q, line_len_d;
  logic [8:0] vl_q, vl_d;
  logic [8:0] frame_lines_q, frame_lines_d;
  logic [8:0] x_q, x_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic [8:0] active_w_q, active_w_d;
  logic [8:0] y_q, y_d;
  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] active_h_q, active_h_d;
  logic       de_q, de_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  state_e     state_q, state_d;
  logic [1:0] mc_q, mc_d;
  logic [8:0] ref_len_q, ref_len_d;
  logic [8:0] ref_lines_q, ref_lines_d;
  logic [8:0] ref_w_q, ref_w_d;
  logic [8:0] ref_h_q, ref_h_d;

  logic hs_fall, vs_fall, hb_fall, hb_rise, vb_fall, vb_rise;
  logic line_cnt, meas_match, len_match, timeout, snap;

  assign hs_fall = hs_q & ~vid.hs;
  assign vs_fall = vs_q & ~vid.vs;
  assign hb_fall = hb_q & ~vid.hb;
  assign hb_rise = ~hb_q & vid.hb;
  assign vb_fall = vb_q & ~vid.vb;
  assign vb_rise = ~vb_q & vid.vb;

  // An hb rise counts as an active line if vb was still low the cycle before,
  // so a rise coinciding with vb rise still belongs to the closing frame.
  assign line_cnt = hb_rise & ~vb_q;

  always_comb begin
    hper_d        = sat_inc(hper_q);
    line_len_d    = line_len_q;
    vl_d          = vl_q;
    frame_lines_d = frame_lines_q;
    x_d           = x_q;
    wcnt_d        = wcnt_q;
    active_w_d    = active_w_q;
    y_d           = y_q;
    hcnt_d        = hcnt_q;
    active_h_d    = active_h_q;
    de_d          = ~vid.hb & ~vid.vb;

    if (hs_fall) begin
      line_len_d = sat_inc(hper_q);
      hper_d     = '0;
    end

    if (vs_fall) begin
      frame_lines_d = hs_fall ? sat_inc(vl_q) : vl_q;
      vl_d          = '0;
    end else if (hs_fall) begin
      vl_d = sat_inc(vl_q);
    end

    if (hb_fall) begin
      x_d = '0;
    end else if (!vid.hb) begin
      x_d = sat_inc(x_q);
    end

    if (hb_rise) begin
      active_w_d = wcnt_q;
      wcnt_d     = '0;
    end else if (!vid.hb) begin
      wcnt_d = sat_inc(wcnt_q);
    end

    if (vb_fall) begin
      y_d = '0;
    end else if (line_cnt) begin
      y_d = sat_inc(y_q);
    end

    if (vb_rise) begin
      active_h_d = line_cnt ? sat_inc(hcnt_q) : hcnt_q;
      hcnt_d     = '0;
    end else if (vb_fall) begin
      hcnt_d = '0;
    end else if (line_cnt) begin
      hcnt_d = sat_inc(hcnt_q);
    end
  end

  // Comparisons use the values being latched this cycle so coincident edges are seen.
  assign len_match  = (line_len_d == ref_len_q);
  assign meas_match = len_match && (frame_lines_d == ref_lines_q) &&
                      (active_w_d == ref_w_q) && (active_h_d == ref_h_q);
  assign timeout    = (hper_d == CntMax);

  always_comb begin
    state_d     = state_q;
    mc_d        = mc_q;
    err_d       = 1'b0;
    snap        = 1'b0;
    ref_len_d   = ref_len_q;
    ref_lines_d = ref_lines_q;
    ref_w_d     = ref_w_q;
    ref_h_d     = ref_h_q;

    unique case (state_q)
      StSearch: begin
        if (vs_fall) begin
          snap    = 1'b1;
          mc_d    = '0;
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (vs_fall) begin
          if (meas_match) begin
            mc_d = mc_q + 2'd1;
            if (mc_d == LockCnt) state_d = StLocked;
          end else begin
            snap = 1'b1;
            mc_d = '0;
          end
        end
      end
      StLocked: begin
        if ((vs_fall && !meas_match) || (hs_fall && !len_match)) begin
          err_d   = 1'b1;
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase

    // A stuck hs holds the FSM in search; only the exit from lock reports an error.
    if (timeout) begin
      state_d = StSearch;
      if (state_q == StLocked) err_d = 1'b1;
    end

    if (snap) begin
      ref_len_d   = line_len_d;
      ref_lines_d = frame_lines_d;
      ref_w_d     = active_w_d;
      ref_h_d     = active_h_d;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hb_q          <= 1'b1;
      vb_q          <= 1'b1;
      hper_q        <= '0;
      line_len_q    <= '0;
      vl_q          <= '0;
      frame_lines_q <= '0;
      x_q           <= '0;
      wcnt_q        <= '0;
      active_w_q    <= '0;
      y_q           <= '0;
      hcnt_q        <= '0;
      active_h_q    <= '0;
      de_q          <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      state_q       <= StSearch;
      mc_q          <= '0;
      ref_len_q     <= '0;
      ref_lines_q   <= '0;
      ref_w_q       <= '0;
      ref_h_q       <= '0;
    end else begin
      hs_q          <= vid.hs;
      vs_q          <= vid.vs;
      hb_q          <= vid.hb;
      vb_q          <= vid.vb;
      hper_q        <= hper_d;
      line_len_q    <= line_len_d;
      vl_q          <= vl_d;
      frame_lines_q <= frame_lines_d;
      x_q           <= x_d;
      wcnt_q        <= wcnt_d;
      active_w_q    <= active_w_d;
      y_q           <= y_d;
      hcnt_q        <= hcnt_d;
      active_h_q    <= active_h_d;
      de_q          <= de_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      state_q       <= state_d;
      mc_q          <= mc_d;
      ref_len_q     <= ref_len_d;
      ref_lines_q   <= ref_lines_d;
      ref_w_q       <= ref_w_d;
      ref_h_q       <= ref_h_d;
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.de          = de_q;
  assign vid.line_len    = line_len_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.active_w    = active_w_q;
  assign vid.active_h    = active_h_q;
  assign vid.locked      = locked_q;
  assign vid.err         = err_q;

endmodule
